// File: rtl/if_stage_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, next-PC select codes
// and the IF/ID payload.
package if_stage_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } if_state_e;

    typedef enum logic [1:0] {
        PC_SEQ = 2'd0,
        PC_BR  = 2'd1,
        PC_J   = 2'd2,
        PC_JR  = 2'd3
    } pcsrc_e;

    typedef struct packed {
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] inst;
        logic            valid;
    } if_id_s;

endpackage

// File: rtl/if_stage_npc_mux.sv
// Next-PC selector: sequential pc+4 or one of the branch/jump/register-jump targets.
module npc_mux
    import if_stage_pkg::*;
(
    input  logic [1:0]      pcsrc,
    input  logic [XLEN-1:0] pc4,
    input  logic [XLEN-1:0] bpc,
    input  logic [XLEN-1:0] jpc,
    input  logic [XLEN-1:0] rpc,
    output logic [XLEN-1:0] npc
);

    always_comb begin
        npc = pc4;
        case (pcsrc_e'(pcsrc))
            PC_SEQ:  npc = pc4;
            PC_BR:   npc = bpc;
            PC_J:    npc = jpc;
            PC_JR:   npc = rpc;
            default: npc = pc4;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, fetch FSM (RST/REQ/HOLD) and stall buffer.
// Define IF_PERF_CNT_EN to build the accepted-fetch counter on fetch_cnt.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            stall,
    input  logic [1:0]      pcsrc,
    input  logic [XLEN-1:0] bpc,
    input  logic [XLEN-1:0] jpc,
    input  logic [XLEN-1:0] rpc,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_rdy,
    input  logic [XLEN-1:0] imem_data,
    output logic [XLEN-1:0] if_pc4,
    output logic [XLEN-1:0] if_inst,
    output logic            if_valid,
    output logic [XLEN-1:0] fetch_cnt
);

    if_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] npc;
    logic            redirect;
    if_id_s          if_id;

    assign pc4      = pc_q + XLEN'(4);
    assign redirect = (pcsrc != 2'd0);

    npc_mux u_npc_mux (
        .pcsrc (pcsrc),
        .pc4   (pc4),
        .bpc   (bpc),
        .jpc   (jpc),
        .rpc   (rpc),
        .npc   (npc)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_RST;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    // A redirect wins over stall and rdy; the squashed slot is presented as a bubble.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        buf_d    = buf_q;
        imem_req = 1'b0;
        if_id    = '0;
        case (state_q)
            ST_RST: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_d = npc;
                end else if (imem_rdy) begin
                    if_id.valid = 1'b1;
                    if_id.inst  = imem_data;
                    if (stall) begin
                        buf_d   = imem_data;
                        state_d = ST_HOLD;
                    end else begin
                        pc_d = npc;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d    = npc;
                    state_d = ST_REQ;
                end else begin
                    if_id.valid = 1'b1;
                    if_id.inst  = buf_q;
                    if (!stall) begin
                        pc_d    = npc;
                        state_d = ST_REQ;
                    end
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
        if (if_id.valid) begin
            if_id.pc4 = pc4;
        end
    end

    assign imem_addr = pc_q;
    assign if_pc4    = if_id.pc4;
    assign if_inst   = if_id.inst;
    assign if_valid  = if_id.valid;

`ifdef IF_PERF_CNT_EN
    logic            accept;
    logic [XLEN-1:0] cnt_q;

    assign accept = !redirect && !stall &&
                    (((state_q == ST_REQ) && imem_rdy) || (state_q == ST_HOLD));

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + XLEN'(1);
        end
    end

    assign fetch_cnt = cnt_q;
`else
    assign fetch_cnt = '0;
`endif

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 clr  input  1  SHALL be the synchronous, active-high reset.
REQ-004 stall  input  1  SHALL be the hazard-unit hold request: keep PC and the presented instruction.
REQ-005 pcsrc  input  2  SHALL select the next PC: 00 pc+4, 01 bpc, 10 jpc, 11 rpc; nonzero means redirect.
REQ-006 bpc, jpc, rpc  input  32 each  SHALL be the branch, jump and register-jump targets.
REQ-007 imem_addr  output  32  SHALL be the fetch address, equal to the PC register.
REQ-008 imem_req  output  1  SHALL be the fetch request to instruction memory.
REQ-009 imem_rdy  input  1  SHALL indicate that imem_data is valid for imem_addr in the same cycle.
REQ-010 imem_data  input  32  SHALL be the fetched instruction word.
REQ-011 if_pc4, if_inst  output  32 each  SHALL be PC+4 and the instruction sent to the IF/ID register.
REQ-012 if_valid  output  1  SHALL mark if_pc4/if_inst as a real instruction.
REQ-013 fetch_cnt  output  32  SHALL be the retired-fetch counter (see Configuration).

Function
REQ-014 The FSM SHALL have states RST, REQ and HOLD; RST SHALL go to REQ unconditionally after one cycle.
REQ-015 imem_req SHALL be 1 only in REQ; it SHALL be 0 in RST and HOLD.
REQ-016 In REQ with imem_rdy=1, the stage SHALL present if_inst=imem_data, if_pc4=pc+4 and if_valid=1 combinationally.
REQ-017 In REQ with imem_rdy=1 and stall=0, pc SHALL load next_pc and the state SHALL remain REQ.
REQ-018 In REQ with imem_rdy=1 and stall=1, the stage SHALL capture imem_data into a holding buffer, keep pc, and go to HOLD.
REQ-019 In REQ with imem_rdy=0, the stage SHALL keep pc, drive if_valid=0 and stay in REQ.
REQ-020 In HOLD, the stage SHALL present the buffer with if_valid=1; when stall=0, pc SHALL load next_pc and the state SHALL go to REQ.
REQ-021 A redirect (pcsrc!=0) in REQ or HOLD SHALL override stall and imem_rdy: pc loads the target, if_valid=0 that cycle, and the next state is REQ.
REQ-022 pcsrc SHALL be ignored in RST.
REQ-023 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0); targets SHALL be used unmodified.
REQ-024 When if_valid=0, if_inst and if_pc4 SHALL be 32'h0, which is a NOP bubble downstream.

Reset
REQ-025 clr=1 at a clock edge SHALL set pc=RESET_PC, state=RST, buffer=0 and fetch_cnt=0, overriding every other input.
REQ-026 During and directly after reset, if_valid, imem_req, if_inst and if_pc4 SHALL be 0.
REQ-027 Reset asserted mid-HOLD or mid-REQ SHALL discard the buffered instruction.

Configuration
REQ-028 With macro IF_PERF_CNT_EN defined, fetch_cnt SHALL increment (wrapping) on every cycle that an if_valid=1 instruction is accepted: REQ with rdy and stall=0 and no redirect, or HOLD leaving with stall=0 and no redirect.
REQ-029 Without IF_PERF_CNT_EN, fetch_cnt SHALL be constant 0 and no counter register SHALL exist.

Structure
REQ-030 A shared package SHALL hold the state encodings (RST=2'd0, REQ=2'd1, HOLD=2'd2) and the pcsrc codes (PC_SEQ, PC_BR, PC_J, PC_JR).
REQ-031 Next-PC selection SHALL be a combinational sub-module, npc_mux; the PC, FSM, buffer and counter SHALL live in if_stage.

Verification
REQ-032 Reset then rdy=1, stall=0 held: imem_addr SHALL be RESET_PC, +4, +8 on consecutive cycles, with if_valid=1 from the first REQ cycle.
REQ-033 Data 32'h2002_0005 with stall=1 for 3 cycles: the state SHALL be HOLD, if_inst SHALL stay 32'h2002_0005, imem_req=0, and pc SHALL be unchanged; after release, pc SHALL advance by 4.
REQ-034 pcsrc=01, bpc=32'h40 while stall=1 in HOLD: the next imem_addr SHALL be 32'h40, with if_valid=0 in the redirect cycle.
REQ-035 pc=32'hFFFF_FFFC, rdy=1: if_pc4 SHALL be 0 and the next imem_addr SHALL be 0.
REQ-036 clr pulsed in HOLD: the next cycle SHALL have if_valid=0 and imem_addr=RESET_PC, and fetch_cnt SHALL be 0.
REQ-037 With IF_PERF_CNT_EN, 5 accepted fetches with 2 stall cycles SHALL give fetch_cnt=5; without the macro, fetch_cnt SHALL be 0.
